// File: rtl/pvr_tex_pkg.sv
// Shared types for the PVR texel fetch unit: pixel-format codes, FSM
// state encoding and helpers for bits-per-pixel and texture size log2.
package pvr_tex_pkg;

  typedef enum logic [2:0] {
    PIX_ARGB1555 = 3'd0,
    PIX_RGB565   = 3'd1,
    PIX_ARGB4444 = 3'd2,
    PIX_YUV422   = 3'd3,
    PIX_PAL4     = 3'd5,
    PIX_PAL8     = 3'd6
  } pix_fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_e;

  typedef enum logic [1:0] {
    BPP_16,
    BPP_8,
    BPP_4
  } bpp_e;

  // Storage class of a format; reserved codes fall back to 16 bpp.
  function automatic bpp_e bpp_of(input logic [2:0] fmt);
    case (pix_fmt_e'(fmt))
      PIX_PAL4: return BPP_4;
      PIX_PAL8: return BPP_8;
      default:  return BPP_16;
    endcase
  endfunction

  // log2 of a power-of-two texture dimension (8..1024).
  function automatic logic [3:0] size_log2(input logic [10:0] size);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      if (size[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pvr_twiddle_idx.sv
// Morton (twiddled) texel index: low log2(min(w,h)) bits of u and v are
// interleaved (v bit k -> 2k, u bit k -> 2k+1); the leftover high bits
// of the larger dimension sit above the interleaved field.
module pvr_twiddle_idx
  import pvr_tex_pkg::*;
(
  input  logic [9:0]  u_i,
  input  logic [9:0]  v_i,
  input  logic [10:0] u_size_i,
  input  logic [10:0] v_size_i,
  output logic [19:0] idx_o
);

  logic [3:0] log_w;
  logic [3:0] log_h;
  logic [3:0] log_min;
  logic [9:0] hi_bits;

  assign log_w   = size_log2(u_size_i);
  assign log_h   = size_log2(v_size_i);
  assign log_min = (log_w < log_h) ? log_w : log_h;

  // Interleave the square part, then append the rectangular remainder.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    idx_o   = '0;
    hi_bits = (log_w > log_h) ? (u_i >> log_min) : (v_i >> log_min);
    for (int k = 0; k < 10; k++) begin
      if (k < int'(log_min)) begin
        idx_o[2*k]   = v_i[k];
        idx_o[2*k+1] = u_i[k];
      end
    end
    idx_o = idx_o | ({10'd0, hi_bits} << {log_min, 1'b0});
  end

endmodule

// File: rtl/pvr_texel_fetch.sv
// PVR texel fetch: turns a (u,v) pair into one 64-bit VRAM word read and
// extracts the addressed 16/8/4 bpp texel for the filter/palette stage.
// Optional single-entry word cache: define PVR_TEX_WORD_CACHE_EN.
module pvr_texel_fetch
  import pvr_tex_pkg::*;
#(
  parameter int VRAM_AW = 20
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               uv_valid,
  output logic               uv_ready,
  input  logic [9:0]         u,
  input  logic [9:0]         v,
  input  logic [10:0]        tex_u_size_full,
  input  logic [10:0]        tex_v_size_full,
  input  logic [22:0]        tex_base_addr,
  input  logic [2:0]         pix_fmt,
  input  logic               twiddled,
  input  logic               tex_change,
  output logic               vram_req,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic               vram_gnt,
  input  logic               vram_rvalid,
  input  logic [63:0]        vram_rdata,
  output logic               texel_valid,
  input  logic               texel_ready,
  output logic [15:0]        texel_data,
  output logic               texel_is_index
);

  state_e state_q, state_d;

  // Fetch parameters captured on acceptance.
  logic [9:0]  u_q, v_q;
  logic [10:0] usz_q, vsz_q;
  logic [22:3] base_q;
  bpp_e        bpp_q;
  logic        tw_q;

  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [2:0]         lane_q, lane_d;
  logic               nib_q, nib_d;
  logic [15:0]        texel_q;
  logic               is_index_q;

  logic [19:0] tw_idx, lin_idx, idx;
  logic [20:0] offset;
  logic [23:0] byte_addr, word_addr;

  logic        cache_hit;
  logic [63:0] cache_word;
  logic [2:0]  unused_base_lsb;

  assign unused_base_lsb = tex_base_addr[2:0];

  // Texel extraction from a little-endian 64-bit word.
  function automatic logic [15:0] pick_texel(input logic [63:0] word, input logic [2:0] lane,
                                             input logic nib, input bpp_e bpp);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = word[{lane[2:1], 4'b0000} +: 16];
    byte_v = word[{lane, 3'b000} +: 8];
    case (bpp)
      BPP_4:   return {12'd0, nib ? byte_v[7:4] : byte_v[3:0]};
      BPP_8:   return {8'd0, byte_v};
      default: return half_v;
    endcase
  endfunction

  pvr_twiddle_idx u_twiddle (
    .u_i      (u_q),
    .v_i      (v_q),
    .u_size_i (usz_q),
    .v_size_i (vsz_q),
    .idx_o    (tw_idx)
  );

  // Coordinates are pre-clamped, so the product never exceeds 20 bits.
  assign lin_idx = {10'd0, v_q} * {9'd0, usz_q} + {10'd0, u_q};
  assign idx     = tw_q ? tw_idx : lin_idx;

  // Byte offset of the texel inside the texture.
  always_comb begin
    case (bpp_q)
      BPP_4:   offset = {2'b00, idx[19:1]};
      BPP_8:   offset = {1'b0, idx};
      default: offset = {idx, 1'b0};
    endcase
  end

  // Addresses past the top of VRAM wrap silently by truncation.
  assign byte_addr = {1'b0, base_q, 3'b000} + {3'b000, offset};
  assign word_addr = byte_addr >> 3;
  assign addr_d    = VRAM_AW'(word_addr);
  assign lane_d    = byte_addr[2:0];
  assign nib_d     = idx[0];

`ifdef PVR_TEX_WORD_CACHE_EN
  logic               cache_vld_q;
  logic [VRAM_AW-1:0] cache_addr_q;
  logic [63:0]        cache_word_q;

  // A pulse on tex_change in the ADDR cycle must already count as a miss.
  assign cache_hit  = cache_vld_q && !tex_change && (cache_addr_q == addr_d);
  assign cache_word = cache_word_q;

  // Cache valid bit: set by a VRAM return, cleared by tex_change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld_q <= 1'b0;
    end else if (tex_change) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_WAIT && vram_rvalid) begin
      cache_vld_q <= 1'b1;
    end
  end

  // Cache payload (tag and word) refilled on every VRAM return.
  // NOTE: payload storage has no reset; the valid bit alone decides whether it is meaningful.
  always_ff @(posedge clock) begin
    if (state_q == ST_WAIT && vram_rvalid) begin
      cache_addr_q <= addr_q;
      cache_word_q <= vram_rdata;
    end
  end
`else
  logic unused_tex_change;

  assign cache_hit         = 1'b0;
  assign cache_word        = '0;
  assign unused_tex_change = tex_change;
`endif

  // Held off while in reset so the upstream never sees a false ready.
  assign uv_ready       = (state_q == ST_IDLE) && reset_n;
  assign vram_addr      = addr_q;
  assign texel_data     = texel_q;
  assign texel_is_index = is_index_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    vram_req    = 1'b0;
    texel_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: if (uv_valid) state_d = ST_ADDR;
      ST_ADDR: state_d = cache_hit ? ST_OUT : ST_REQ;
      ST_REQ: begin
        vram_req = 1'b1;
        if (vram_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: if (vram_rvalid) state_d = ST_OUT;
      ST_OUT: begin
        texel_valid = 1'b1;
        if (texel_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, address in ADDR, texel on return or hit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_q        <= '0;
      v_q        <= '0;
      usz_q      <= '0;
      vsz_q      <= '0;
      base_q     <= '0;
      bpp_q      <= BPP_16;
      tw_q       <= 1'b0;
      addr_q     <= '0;
      lane_q     <= '0;
      nib_q      <= 1'b0;
      texel_q    <= '0;
      is_index_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && uv_valid) begin
        u_q    <= u;
        v_q    <= v;
        usz_q  <= tex_u_size_full;
        vsz_q  <= tex_v_size_full;
        base_q <= tex_base_addr[22:3];
        bpp_q  <= bpp_of(pix_fmt);
        tw_q   <= twiddled;
      end
      if (state_q == ST_ADDR) begin
        addr_q     <= addr_d;
        lane_q     <= lane_d;
        nib_q      <= nib_d;
        is_index_q <= (bpp_q != BPP_16);
        if (cache_hit) texel_q <= pick_texel(cache_word, lane_d, nib_d, bpp_q);
      end
      if (state_q == ST_WAIT && vram_rvalid) begin
        texel_q <= pick_texel(vram_rdata, lane_q, nib_q, bpp_q);
      end
    end
  end

endmodule

// File: tb/tb_pvr_texel_fetch.sv
// Self-checking bench for pvr_texel_fetch: a table of hand-computed
// fetch vectors run through a VRAM responder model, plus hand-written
// sequences for reset, mid-fetch reset and the optional word cache.
module tb_pvr_texel_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        uv_valid, uv_ready;
  logic [9:0]  u, v;
  logic [10:0] tex_u_size_full, tex_v_size_full;
  logic [22:0] tex_base_addr;
  logic [2:0]  pix_fmt;
  logic        twiddled, tex_change;
  logic        vram_req, vram_gnt, vram_rvalid;
  logic [19:0] vram_addr;
  logic [63:0] vram_rdata;
  logic        texel_valid, texel_ready, texel_is_index;
  logic [15:0] texel_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pvr_texel_fetch #(.VRAM_AW(20)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .uv_valid        (uv_valid),
    .uv_ready        (uv_ready),
    .u               (u),
    .v               (v),
    .tex_u_size_full (tex_u_size_full),
    .tex_v_size_full (tex_v_size_full),
    .tex_base_addr   (tex_base_addr),
    .pix_fmt         (pix_fmt),
    .twiddled        (twiddled),
    .tex_change      (tex_change),
    .vram_req        (vram_req),
    .vram_addr       (vram_addr),
    .vram_gnt        (vram_gnt),
    .vram_rvalid     (vram_rvalid),
    .vram_rdata      (vram_rdata),
    .texel_valid     (texel_valid),
    .texel_ready     (texel_ready),
    .texel_data      (texel_data),
    .texel_is_index  (texel_is_index)
  );

  typedef struct {
    logic [9:0]  u, v;
    logic [10:0] w, h;
    logic [22:0] base;
    logic [2:0]  fmt;
    logic        tw;
    int          gnt_dly, rv_dly, rdy_dly;
    logic [19:0] exp_addr;
    int          exp_shift, exp_bits;
    logic        exp_index;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];

  function automatic vec_t mk(input int uu, input int vv, input int w, input int h, input int base,
                              input int fmt, input int tw, input int gd, input int rd, input int yd,
                              input int addr, input int sh, input int bits, input int isx);
    vec_t t;
    t.u = 10'(uu); t.v = 10'(vv); t.w = 11'(w); t.h = 11'(h);
    t.base = 23'(base); t.fmt = 3'(fmt); t.tw = 1'(tw);
    t.gnt_dly = gd; t.rv_dly = rd; t.rdy_dly = yd;
    t.exp_addr = 20'(addr); t.exp_shift = sh; t.exp_bits = bits; t.exp_index = 1'(isx);
    return t;
  endfunction

  // VRAM content: a fixed hash of the word address.
  function automatic logic [63:0] mem_word(input logic [19:0] a);
    return ({44'd0, a} * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [15:0] exp_texel(input vec_t t);
    logic [63:0] w;
    w = (mem_word(t.exp_addr) >> t.exp_shift) & ((64'd1 << t.exp_bits) - 64'd1);
    return w[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired without the required DUT response", name);
  endtask

  // Present one coordinate, act as VRAM, then drain the texel.
  task automatic run_fetch(input vec_t t, output int reqs, output int req_cyc, output int valid_cyc);
    int cyc, gwait, rwait, hold, rv_cyc;
    bit granted, returned, done;
    logic [15:0] held_data;
    logic        held_idx;
    logic [19:0] req_addr;
    vec_t e;
    reqs = 0; req_cyc = -1; valid_cyc = -1; rv_cyc = -1;
    gwait = 0; rwait = 0; hold = 0;
    granted = 0; returned = 0; done = 0;
    held_data = '0; held_idx = 1'b0; req_addr = '0;

    @(negedge clock);
    u = t.u; v = t.v; tex_u_size_full = t.w; tex_v_size_full = t.h;
    tex_base_addr = t.base; pix_fmt = t.fmt; twiddled = t.tw; uv_valid = 1'b1;
    sb_q.push_back(t);
    cyc = 0;
    while (!uv_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    if (!uv_ready) begin
      bound_fail("uv_accept");
      uv_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end

    // Acceptance happened at the posedge; scramble inputs to prove capture.
    @(negedge clock);
    uv_valid = 1'b0;
    u = ~t.u; v = ~t.v; tex_u_size_full = 11'd8; tex_v_size_full = 11'd1024;
    tex_base_addr = ~t.base; pix_fmt = ~t.fmt; twiddled = ~t.tw;
    cyc = 1;
    while (!done && cyc < 200) begin
      vram_gnt = 1'b0; vram_rvalid = 1'b0; vram_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      if (texel_valid) begin
        if (valid_cyc < 0) begin
          valid_cyc = cyc;
          held_data = texel_data;
          held_idx  = texel_is_index;
        end
        if (hold < t.rdy_dly) begin
          if (cyc > valid_cyc) begin
            check("hold_texel_data", texel_data, held_data);
            check("hold_texel_is_index", texel_is_index, held_idx);
          end
          check("hold_uv_ready", uv_ready, 1'b0);
          vram_rvalid = 1'b1;
          vram_rdata  = ~mem_word(t.exp_addr);
          texel_ready = 1'b0;
          hold++;
        end else begin
          e = sb_q.pop_front();
          check("texel_data", texel_data, exp_texel(e));
          check("texel_is_index", texel_is_index, e.exp_index);
          texel_ready = 1'b1;
          done = 1;
        end
      end else if (vram_req && !granted) begin
        if (req_cyc < 0) begin
          req_cyc = cyc;
          check("vram_addr", vram_addr, sb_q[0].exp_addr);
        end else begin
          check("vram_addr_stable", vram_addr, sb_q[0].exp_addr);
        end
        if (gwait >= t.gnt_dly) begin
          vram_gnt = 1'b1;
          granted  = 1;
          req_addr = vram_addr;
          reqs++;
        end else begin
          gwait++;
        end
      end else if (granted && !returned) begin
        if (rwait == 0) check("vram_req_drop", vram_req, 1'b0);
        if (rwait >= t.rv_dly) begin
          vram_rvalid = 1'b1;
          vram_rdata  = mem_word(req_addr);
          returned    = 1;
          rv_cyc      = cyc;
        end else begin
          rwait++;
        end
      end
      @(negedge clock);
      cyc++;
    end
    texel_ready = 1'b0; vram_gnt = 1'b0; vram_rvalid = 1'b0;
    if (!done) begin
      bound_fail("texel_out");
      void'(sb_q.pop_front());
    end else if (returned) begin
      check("miss_latency", valid_cyc, rv_cyc + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs, req_cyc, valid_cyc;
    vec_t c1, c2;

    //        u    v    w    h    base      fmt tw gd rd yd addr     sh bits idx
    vecs[0] = mk(3,   2,   64,  64,  'h1000,   1, 0, 0, 0, 5, 'h220,   48, 16, 0);
    vecs[1] = mk(2,   1,   8,   8,   0,        0, 1, 2, 1, 0, 'h2,     16, 16, 0);
    vecs[2] = mk(8,   0,   16,  8,   0,        3, 1, 0, 3, 1, 'h10,     0, 16, 0);
    vecs[3] = mk(1,   0,   8,   8,   0,        5, 0, 1, 0, 0, 'h0,      4,  4, 1);
    vecs[4] = mk(5,   1,   32,  32,  'h200D,   6, 0, 0, 0, 2, 'h405,   40,  8, 1);
    vecs[5] = mk(6,   0,   8,   8,   0,        5, 0, 3, 2, 0, 'h0,     24,  4, 1);
    vecs[6] = mk(1023,1023,1024,1024,'h7FFFF8, 1, 0, 0, 0, 0, 'h3FFFE, 48, 16, 0);
    vecs[7] = mk(2,   0,   16,  16,  0,        4, 0, 1, 1, 0, 'h0,     32, 16, 0);
    vecs[8] = mk(7,   9,   8,   16,  0,        2, 1, 0, 0, 0, 'h1A,    48, 16, 0);
    vecs[9] = mk(5,   3,   32,  32,  'h100,    6, 1, 0, 1, 0, 'h24,    56,  8, 1);

    // Reset with a stale VRAM return on the bus.
    reset_n = 1'b0; uv_valid = 1'b0; u = '0; v = '0;
    tex_u_size_full = 11'd8; tex_v_size_full = 11'd8; tex_base_addr = '0;
    pix_fmt = '0; twiddled = 1'b0; tex_change = 1'b0;
    vram_gnt = 1'b0; vram_rvalid = 1'b1; vram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    texel_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_uv_ready", uv_ready, 1'b0);
    check("reset_vram_req", vram_req, 1'b0);
    check("reset_vram_addr", vram_addr, 20'd0);
    check("reset_texel_valid", texel_valid, 1'b0);
    check("reset_texel_data", texel_data, 16'd0);
    check("reset_texel_is_index", texel_is_index, 1'b0);
    reset_n = 1'b1;
    #1;
    check("post_reset_uv_ready", uv_ready, 1'b1);
    repeat (2) @(negedge clock);
    check("stale_rvalid_vram_req", vram_req, 1'b0);
    check("stale_rvalid_texel_valid", texel_valid, 1'b0);
    check("stale_rvalid_uv_ready", uv_ready, 1'b1);
    vram_rvalid = 1'b0;

    // Table of fetches; none of them repeats the previous word address.
    for (int i = 0; i < 10; i++) begin
      run_fetch(vecs[i], reqs, req_cyc, valid_cyc);
      check("vec_req_count", reqs, 1);
      check("vec_req_cycle", req_cyc, 2);
    end

    // Reset asserted while the request is pending.
    @(negedge clock);
    u = 10'd3; v = 10'd2; tex_u_size_full = 11'd64; tex_v_size_full = 11'd64;
    tex_base_addr = 23'h1000; pix_fmt = 3'd1; twiddled = 1'b0; uv_valid = 1'b1;
    @(negedge clock);
    uv_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!vram_req && n < 10) begin
        @(negedge clock);
        n++;
      end
      if (!vram_req) bound_fail("midreset_req");
    end
    #2 reset_n = 1'b0;
    #1;
    check("midreset_vram_req", vram_req, 1'b0);
    check("midreset_uv_ready", uv_ready, 1'b0);
    check("midreset_vram_addr", vram_addr, 20'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("midreset_idle", uv_ready, 1'b1);
    @(negedge clock);
    check("midreset_no_resume", vram_req, 1'b0);
    run_fetch(vecs[1], reqs, req_cyc, valid_cyc);
    check("recover_req_count", reqs, 1);

    // Two fetches to one word, then again after a texture change.
    c1 = mk(3, 2, 64, 64, 'h1000, 1, 0, 0, 0, 0, 'h220, 48, 16, 0);
    c2 = mk(2, 2, 64, 64, 'h1000, 1, 0, 0, 0, 0, 'h220, 32, 16, 0);
    run_fetch(c1, reqs, req_cyc, valid_cyc);
    check("cache_first_reqs", reqs, 1);
    run_fetch(c2, reqs, req_cyc, valid_cyc);
`ifdef PVR_TEX_WORD_CACHE_EN
    check("cache_hit_reqs", reqs, 0);
    check("cache_hit_latency", valid_cyc, 2);
`else
    check("nocache_reqs", reqs, 1);
    check("nocache_req_cycle", req_cyc, 2);
`endif
    @(negedge clock);
    tex_change = 1'b1;
    @(negedge clock);
    tex_change = 1'b0;
    run_fetch(c2, reqs, req_cyc, valid_cyc);
    check("tex_change_reqs", reqs, 1);
    check("tex_change_req_cycle", req_cyc, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
